// File: rtl/frame_deserializer_if.sv
// rtl/frame_deserializer_if.sv - serial timestamp link receive-side signal bundle
interface frame_deserializer_if;
    logic        din;
    logic [31:0] data_out;
    logic        valid;
    logic        sync_err;
    logic        busy;

    modport master (
        output din,
        input  data_out,
        input  valid,
        input  sync_err,
        input  busy
    );

    modport slave (
        input  din,
        output data_out,
        output valid,
        output sync_err,
        output busy
    );
endinterface

// File: rtl/frame_deserializer.sv
// rtl/frame_deserializer.sv - 40-bit sync-framed serial to 32-bit word decoder
module frame_deserializer #(
    parameter int IDLE_GAP = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    frame_deserializer_if.slave  link
);
    localparam int GW = $clog2(IDLE_GAP + 1);

    typedef enum logic [2:0] {
        S_HOLDOFF,
        S_IDLE,
        S_DATA,
        S_SYNC0,
        S_SYNC1
    } state_t;

    state_t        state_q;
    logic          s1_q;
    logic          s2_q;
    logic          prev_q;
    logic [GW-1:0] gapcnt_q;
    logic [2:0]    bitcnt_q;
    logic [1:0]    bytecnt_q;
    logic [31:0]   word_q;
    logic [31:0]   word_nx;
    logic [31:0]   data_out_q;
    logic          valid_q;
    logic          sync_err_q;
    logic          busy_q;

    // Current sample written into its final bit position of the word
    always_comb begin
        word_nx = word_q;
        word_nx[{bytecnt_q, bitcnt_q}] = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HOLDOFF;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            prev_q     <= 1'b0;
            gapcnt_q   <= '0;
            bitcnt_q   <= '0;
            bytecnt_q  <= '0;
            word_q     <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s1_q       <= link.din;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;

            unique case (state_q)
                S_HOLDOFF: begin
                    if (s2_q) begin
                        gapcnt_q <= '0;
                    end else if (gapcnt_q == GW'(IDLE_GAP - 1)) begin
                        gapcnt_q <= '0;
                        state_q  <= S_IDLE;
                    end else begin
                        gapcnt_q <= gapcnt_q + GW'(1);
                    end
                end
                S_IDLE: begin
                    // Only a genuine low-to-high transition marks the first sync
                    if (!prev_q && s2_q) begin
                        bitcnt_q  <= '0;
                        bytecnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    word_q   <= word_nx;
                    bitcnt_q <= bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (bytecnt_q == 2'd3) begin
                            data_out_q <= word_nx;
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            bytecnt_q <= bytecnt_q + 2'd1;
                            state_q   <= S_SYNC0;
                        end
                    end
                end
                S_SYNC0: begin
                    if (s2_q) begin
                        sync_err_q <= 1'b1;
                        busy_q     <= 1'b0;
                        gapcnt_q   <= '0;
                        state_q    <= S_HOLDOFF;
                    end else begin
                        state_q <= S_SYNC1;
                    end
                end
                S_SYNC1: begin
                    if (!s2_q) begin
                        sync_err_q <= 1'b1;
                        busy_q     <= 1'b0;
                        gapcnt_q   <= '0;
                        state_q    <= S_HOLDOFF;
                    end else begin
                        bitcnt_q <= '0;
                        state_q  <= S_DATA;
                    end
                end
                default: begin
                    gapcnt_q <= '0;
                    state_q  <= S_HOLDOFF;
                end
            endcase
        end
    end

    assign link.data_out = data_out_q;
    assign link.valid    = valid_q;
    assign link.sync_err = sync_err_q;
    assign link.busy     = busy_q;
endmodule

// File: tb/tb_frame_deserializer.sv
// tb/tb_frame_deserializer.sv - scoreboard bench for frame_deserializer
module tb_frame_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #2 clk = ~clk;

    frame_deserializer_if link();

    frame_deserializer #(.IDLE_GAP(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    typedef struct {
        logic [31:0] w;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          err_q[$];
    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          n_valid    = 0;
    int          n_sent     = 0;
    int          n_err      = 0;
    int          n_err_exp  = 0;
    logic [31:0] last_word  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %h expected no event", name, act);
    endtask

    // Serializer model: byte b occupies bits 10b..10b+9 as 0,1 then eight data bits LSB first
    function automatic logic frame_bit(input logic [31:0] w, input int i);
        int b;
        int p;
        b = i / 10;
        p = i % 10;
        if (p == 0) return 1'b0;
        if (p == 1) return 1'b1;
        return w[8 * b + p - 2];
    endfunction

    // mode: 0 decoded, 1 ignored, 2 corrupt bad_bit, 3 truncated after nbits
    task automatic send_frame(input logic [31:0] w, input int mode, input int bad_bit, input int nbits);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = frame_bit(w, i);
            if (mode == 2 && i == bad_bit) b = ~b;
            link.din = b;
            @(posedge clk);
            #1;
            if (mode == 2 && i == bad_bit) begin
                err_q.push_back(cyc + 2);
                n_err_exp++;
            end
            if (i == 20) check("busy_mid_frame", {31'b0, link.busy}, {31'b0, (mode == 0 || mode == 3)});
            if (i == 39 && mode == 0) begin
                exp_q.push_back('{w, cyc + 2});
                n_sent++;
            end
        end
        link.din = 1'b0;
    endtask

    task automatic idle(input int n);
        link.din = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (!rst) begin
            if (link.valid && link.sync_err) flag("valid_and_sync_err", link.data_out);
            if (link.valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    flag("unexpected_valid", link.data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", link.data_out, e.w);
                    check("valid_latency", cyc, e.due);
                    last_word = e.w;
                end
            end
            if (link.sync_err) begin
                n_err++;
                if (err_q.size() == 0) begin
                    flag("unexpected_sync_err", link.data_out);
                end else begin
                    d = err_q.pop_front();
                    check("sync_err_latency", cyc, d);
                    check("data_out_hold", link.data_out, last_word);
                end
            end
        end
    end

    initial begin
        link.din = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", link.data_out, 32'h0);
        check("reset_valid", {31'b0, link.valid}, 32'h0);
        check("reset_sync_err", {31'b0, link.sync_err}, 32'h0);
        check("reset_busy", {31'b0, link.busy}, 32'h0);
        rst = 1'b0;

        idle(20);
        send_frame(32'hDEADBEEF, 0, 0, 40);
        idle(3);
        send_frame(32'h00000000, 0, 0, 40);
        idle(3);
        send_frame(32'hFFFFFFFF, 0, 0, 40);
        idle(3);

        send_frame(32'h12345678, 2, 11, 40);
        idle(16);
        send_frame(32'hCAFEF00D, 0, 0, 40);
        idle(5);

        // Line stuck high through reset release: the following frame arrives too soon
        link.din = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_word = '0;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        idle(5);
        send_frame(32'h3C3C0FF0, 1, 0, 40);
        idle(20);
        send_frame(32'h0BADF00D, 0, 0, 40);
        idle(5);

        // Reset in the middle of byte 2
        send_frame(32'h55AA33CC, 3, 0, 25);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_word = '0;
        check("midreset_data_out", link.data_out, 32'h0);
        check("midreset_busy", {31'b0, link.busy}, 32'h0);
        idle(16);
        send_frame(32'hA5A55A5A, 0, 0, 40);

        for (int k = 0; k < 100; k++) begin
            idle($urandom_range(3, 10));
            send_frame($urandom, 0, 0, 40);
        end
        idle(12);

        check("pending_valid", exp_q.size(), 32'h0);
        check("pending_sync_err", err_q.size(), 32'h0);
        check("valid_count", n_valid, n_sent);
        check("sync_err_count", n_err, n_err_exp);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
